// File: rtl/jtcps2_keytx.sv
// jtcps2_keytx
// Serialises a CPS2 decryption key frame to the key-loader port.
// On an accepted start, addr_rng and key are captured into a 160-bit cfg word.
// The cfg word is scrambled into the loader's raw bit order. Twenty bytes are
// then sent LSB byte first. Each byte is held for WE_HIGH cycles with dout_we
// high, then for WE_LOW cycles with dout_we low. A running checksum is kept
// in sum.
//
// Ports
//   clk       clock, rising edge
//   rst       asynchronous active-high reset
//   start     frame request, only looked at while busy is low
//   addr_rng  16-bit address-range field
//   key       64-bit decryption key
//   dout      byte presented to the loader
//   dout_we   byte strobe, loader captures dout on its rising edge
//   busy      frame in progress
//   done      one-cycle pulse when the frame completes
//   sum       running checksum of the bytes sent in this frame
module jtcps2_keytx #(
    parameter int WE_HIGH = 2,
    parameter int WE_LOW  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] addr_rng,
    input  logic [63:0] key,
    output logic [7:0]  dout,
    output logic        dout_we,
    output logic        busy,
    output logic        done,
    output logic [11:0] sum
);

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW,
        DONE
    } state_t;

    localparam logic [3:0] H_LAST    = 4'(WE_HIGH - 1);
    localparam logic [3:0] L_LAST    = 4'(WE_LOW - 1);
    localparam logic [4:0] LAST_BYTE = 5'd19;

    // Base bit position in raw for each 16-bit cfg slice, indexed by slice.
    localparam int BASE [10] = '{128, 144, 96, 112, 80, 64, 48, 32, 16, 0};

    state_t         state;
    state_t         next_state;
    logic [3:0]     phase;
    logic [4:0]     byte_cnt;
    logic [159:0]   cfg;
    logic [159:0]   raw_map;
    logic [159:0]   raw_q;
    logic           accept;
    logic           phase_end;
    logic           next_byte;

    // One checksum step. The byte is sign-extended to 12 bits before the add.
    function automatic logic [11:0] sum_step(input logic [11:0] s, input logic [7:0] d);
        logic [11:0] t;
        t = ((d & 8'hCF) != 8'h00) ? (s ^ 12'h065) : s;
        return t + {{4{d[7]}}, d};
    endfunction

    assign cfg = {addr_rng, 80'h0, key};

    // Scramble cfg into loader bit order. Within a slice, the top six bits go
    // reversed to base+10..base+15. The middle eight go reversed to
    // base..base+7. The two lowest bits land at +8/+9 of the preceding base,
    // wrapping around the 160-bit word.
    for (genvar k = 0; k < 10; k++) begin : g_slice
        for (genvar j = 0; j < 6; j++) begin : g_hi
            assign raw_map[BASE[k] + 10 + j] = cfg[16*k + 15 - j];
        end
        for (genvar j = 0; j < 8; j++) begin : g_lo
            assign raw_map[BASE[k] + j] = cfg[16*k + 9 - j];
        end
        assign raw_map[(BASE[k] + 152) % 160] = cfg[16*k + 1];
        assign raw_map[(BASE[k] + 153) % 160] = cfg[16*k];
    end

    // State register. Reset is asynchronous, so dout_we drops at once when
    // rst rises mid-frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and the strobes derived from state. accept and
    // next_byte tell the datapath when to load a new byte.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        phase_end  = 1'b0;
        next_byte  = 1'b0;
        dout_we    = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    next_state = HIGH;
                end
            end
            HIGH: begin
                dout_we   = 1'b1;
                busy      = 1'b1;
                phase_end = (phase == H_LAST);
                if (phase_end) begin
                    next_state = LOW;
                end
            end
            LOW: begin
                busy      = 1'b1;
                phase_end = (phase == L_LAST);
                if (phase_end) begin
                    if (byte_cnt == LAST_BYTE) begin
                        next_state = DONE;
                    end else begin
                        next_byte  = 1'b1;
                        next_state = HIGH;
                    end
                end
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Datapath. The scrambled word is captured on accept and then shifted
    // down a byte at a time, so the next byte is always in raw_q[15:8]. dout
    // and sum change only on entry to HIGH. Both therefore hold steady through
    // a byte and after the frame ends.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase    <= 4'd0;
            byte_cnt <= 5'd0;
            raw_q    <= '0;
            dout     <= 8'h00;
            sum      <= 12'h000;
        end else if (accept) begin
            phase    <= 4'd0;
            byte_cnt <= 5'd0;
            raw_q    <= raw_map;
            dout     <= raw_map[7:0];
            sum      <= sum_step(12'h000, raw_map[7:0]);
        end else if (next_byte) begin
            phase    <= 4'd0;
            byte_cnt <= byte_cnt + 5'd1;
            raw_q    <= {8'h00, raw_q[159:8]};
            dout     <= raw_q[15:8];
            sum      <= sum_step(sum, raw_q[15:8]);
        end else if (busy) begin
            phase <= phase_end ? 4'd0 : phase + 4'd1;
        end
    end

endmodule

// File: tb/tb_jtcps2_keytx.sv
// tb_jtcps2_keytx
// Bench for jtcps2_keytx. It runs a default-timing instance and a fast
// instance (WE_HIGH=WE_LOW=1) side by side. A loader model rebuilds the raw
// word from the dout_we rising edges. A permutation table decodes that word
// back to addr_rng/key. The checksum is recomputed from the expected bytes.
module tb_jtcps2_keytx;

    localparam int WH = 2;
    localparam int WL = 2;
    localparam int FRAME_A = 20 * (WH + WL) + 1;
    localparam int FRAME_F = 20 * (1 + 1) + 1;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] addr_rng;
    logic [63:0] key;
    logic [7:0]  dout;
    logic        dout_we;
    logic        busy;
    logic        done;
    logic [11:0] sum;
    logic [7:0]  f_dout;
    logic        f_we;
    logic        f_busy;
    logic        f_done;
    logic [11:0] f_sum;
    logic        clr;

    int vectors;
    int miscompares;
    int src_of [160];

    jtcps2_keytx #(.WE_HIGH(WH), .WE_LOW(WL)) dut (
        .clk(clk), .rst(rst), .start(start), .addr_rng(addr_rng), .key(key),
        .dout(dout), .dout_we(dout_we), .busy(busy), .done(done), .sum(sum)
    );

    jtcps2_keytx #(.WE_HIGH(1), .WE_LOW(1)) dut_fast (
        .clk(clk), .rst(rst), .start(start), .addr_rng(addr_rng), .key(key),
        .dout(f_dout), .dout_we(f_we), .busy(f_busy), .done(f_done), .sum(f_sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Loader model and frame statistics for the default instance. These are
    // sampled on the falling edge, away from the active edge. clr restarts
    // them at the beginning of each frame.
    logic         prev_we;
    int           strobes, done_cnt, busy_cyc, tick, unstable;
    int           done_ticks [4];
    logic [159:0] ldr_raw;
    logic [7:0]   last_byte;
    logic [11:0]  sum_log [64];

    always @(negedge clk) begin
        prev_we <= dout_we;
        if (clr) begin
            strobes  <= 0;
            done_cnt <= 0;
            busy_cyc <= 0;
            tick     <= 0;
            unstable <= 0;
            ldr_raw  <= '0;
        end else begin
            tick <= tick + 1;
            if (busy || done) busy_cyc <= busy_cyc + 1;
            if (done) begin
                if (done_cnt < 4) done_ticks[done_cnt] <= tick + 1;
                done_cnt <= done_cnt + 1;
            end
            if (dout_we && !prev_we) begin
                ldr_raw   <= {dout, ldr_raw[159:8]};
                last_byte <= dout;
                if (strobes < 64) sum_log[strobes] <= sum;
                strobes <= strobes + 1;
            end else if (busy && dout !== last_byte) begin
                unstable <= unstable + 1;
            end
        end
    end

    // The same loader model for the fast instance. It also counts any cycle
    // where the strobe stays high twice in a row.
    logic         f_prev;
    int           f_strobes, f_done_cnt, f_done_tick, f_tick, f_bad, f_cyc;
    logic [159:0] f_raw;

    always @(negedge clk) begin
        f_prev <= f_we;
        if (clr) begin
            f_strobes   <= 0;
            f_done_cnt  <= 0;
            f_done_tick <= 0;
            f_tick      <= 0;
            f_bad       <= 0;
            f_cyc       <= 0;
            f_raw       <= '0;
        end else begin
            f_tick <= f_tick + 1;
            if (f_busy || f_done) f_cyc <= f_cyc + 1;
            if (f_done) begin
                if (f_done_cnt == 0) f_done_tick <= f_tick + 1;
                f_done_cnt <= f_done_cnt + 1;
            end
            if (f_we && f_prev) f_bad <= f_bad + 1;
            if (f_we && !f_prev) begin
                f_raw     <= {f_dout, f_raw[159:8]};
                f_strobes <= f_strobes + 1;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Builds the table saying which cfg bit lands at each raw bit.
    task automatic buildTable();
        int base_tab [10];
        int b;
        base_tab = '{128, 144, 96, 112, 80, 64, 48, 32, 16, 0};
        for (int k = 0; k < 10; k++) begin
            b = base_tab[k];
            for (int j = 0; j < 6; j++) src_of[b + 10 + j] = 16*k + 15 - j;
            for (int j = 0; j < 8; j++) src_of[b + j] = 16*k + 9 - j;
            src_of[(b + 152) % 160] = 16*k + 1;
            src_of[(b + 153) % 160] = 16*k;
        end
    endtask

    function automatic logic [159:0] encode(input logic [15:0] a, input logic [63:0] k);
        logic [159:0] c;
        logic [159:0] r;
        c = {a, 80'h0, k};
        for (int i = 0; i < 160; i++) r[i] = c[src_of[i]];
        return r;
    endfunction

    function automatic logic [159:0] decode(input logic [159:0] r);
        logic [159:0] c;
        c = '0;
        for (int i = 0; i < 160; i++) c[src_of[i]] = r[i];
        return c;
    endfunction

    function automatic int model_sum(input logic [159:0] r, input int nbytes);
        int s;
        int d;
        s = 0;
        for (int n = 0; n < nbytes; n++) begin
            d = int'(r[8*n +: 8]);
            if ((d & 'hCF) != 0) s = s ^ 'h65;
            s = (s + d + ((d >= 128) ? 'hF00 : 0)) % 4096;
        end
        return s;
    endfunction

    // Sends one frame. A start pulse is injected once strobes reaches
    // pulse_at. Reset is asserted during a strobe once strobes reaches
    // reset_at. Either may be -1 to disable it.
    task automatic applyStimulus(input logic [15:0] a, input logic [63:0] k,
                                 input int pulse_at, input int reset_at);
        int           guard;
        bit           pulsed;
        bit           aborted;
        logic [159:0] exp_raw;
        logic [159:0] dec;
        exp_raw = encode(a, k);
        @(posedge clk); #1;
        clr = 1'b1; addr_rng = a; key = k; start = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0; start = 1'b0;
        addr_rng = 16'($urandom);
        key = {$urandom, $urandom};
        guard = 0; pulsed = 0; aborted = 0;
        while (done_cnt == 0 && guard < 400 && !aborted) begin
            @(posedge clk); #1;
            guard++;
            start = 1'b0;
            if (!pulsed && strobes == pulse_at) begin
                start = 1'b1;
                pulsed = 1;
            end
            if (strobes == reset_at && dout_we) begin
                rst = 1'b1;
                #1;
                checkOutput("rst_we_drop", 64'(dout_we), 64'd0);
                checkOutput("rst_busy", 64'(busy), 64'd0);
                checkOutput("rst_sum", 64'(sum), 64'd0);
                checkOutput("rst_dout", 64'(dout), 64'd0);
                aborted = 1;
            end
        end
        start = 1'b0;
        if (aborted) begin
            @(posedge clk); #1;
            rst = 1'b0;
            repeat (30) @(posedge clk);
            #1;
            checkOutput("abort_no_done", 64'(done_cnt), 64'd0);
            checkOutput("abort_idle", 64'(busy), 64'd0);
            return;
        end
        checkOutput("done_seen", 64'(done_cnt > 0), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("no_requeue", 64'(busy), 64'd0);
        checkOutput("done_count", 64'(done_cnt), 64'd1);
        checkOutput("done_latency", 64'(done_ticks[0]), 64'(FRAME_A));
        checkOutput("frame_cycles", 64'(busy_cyc), 64'(FRAME_A));
        checkOutput("strobe_count", 64'(strobes), 64'd20);
        checkOutput("dout_stable", 64'(unstable), 64'd0);
        for (int n = 0; n < 20; n++) begin
            checkOutput("byte", 64'(ldr_raw[8*n +: 8]), 64'(exp_raw[8*n +: 8]));
            checkOutput("run_sum", 64'(sum_log[n]), 64'(model_sum(exp_raw, n + 1)));
        end
        dec = decode(ldr_raw);
        checkOutput("dec_addr", 64'(dec[159:144]), 64'(a));
        checkOutput("dec_key", dec[63:0], k);
        checkOutput("dec_zero", 64'(|dec[143:64]), 64'd0);
        checkOutput("final_sum", 64'(sum), 64'(model_sum(exp_raw, 20)));
        checkOutput("f_strobes", 64'(f_strobes), 64'd20);
        checkOutput("f_done_count", 64'(f_done_cnt), 64'd1);
        checkOutput("f_done_latency", 64'(f_done_tick), 64'(FRAME_F));
        checkOutput("f_frame_cycles", 64'(f_cyc), 64'(FRAME_F));
        checkOutput("f_we_low_gap", 64'(f_bad), 64'd0);
        dec = decode(f_raw);
        checkOutput("f_dec_addr", 64'(dec[159:144]), 64'(a));
        checkOutput("f_dec_key", dec[63:0], k);
        checkOutput("f_sum", 64'(f_sum), 64'(model_sum(exp_raw, 20)));
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [15:0]  ra;
        logic [63:0]  rk;
        logic [159:0] er;
        int           guard;
        vectors = 0;
        miscompares = 0;
        rst = 1'b1; start = 1'b0; clr = 1'b0; addr_rng = '0; key = '0;
        buildTable();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_dout", 64'(dout), 64'd0);
        checkOutput("reset_we", 64'(dout_we), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_done", 64'(done), 64'd0);
        checkOutput("reset_sum", 64'(sum), 64'd0);
        rst = 1'b0;

        applyStimulus(16'h0000, 64'h0, -1, -1);
        checkOutput("zero_sum", 64'(sum), 64'h000);

        applyStimulus(16'h8000, 64'h0, -1, -1);
        checkOutput("addr_msb_byte1", 64'(ldr_raw[15:8]), 64'h04);
        checkOutput("addr_msb_sum", 64'(sum), 64'h069);

        applyStimulus(16'h0000, 64'h1, -1, -1);
        checkOutput("key_lsb_byte15", 64'(ldr_raw[127:120]), 64'h02);
        checkOutput("key_lsb_sum", 64'(sum), 64'h067);

        applyStimulus(16'($urandom), {$urandom, $urandom}, 8, -1);
        applyStimulus(16'($urandom), {$urandom, $urandom}, -1, 11);
        applyStimulus(16'($urandom), {$urandom, $urandom}, -1, -1);

        for (int i = 0; i < 400; i++) begin
            applyStimulus(16'($urandom), {$urandom, $urandom}, -1, -1);
        end

        // start held high must chain frames, with one idle cycle between them
        ra = 16'($urandom);
        rk = {$urandom, $urandom};
        er = encode(ra, rk);
        @(posedge clk); #1;
        clr = 1'b1; addr_rng = ra; key = rk; start = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        guard = 0;
        while (done_cnt < 2 && guard < 500) begin
            @(posedge clk); #1;
            guard++;
        end
        checkOutput("held_two_frames", 64'(done_cnt), 64'd2);
        checkOutput("held_done0", 64'(done_ticks[0]), 64'(FRAME_A));
        checkOutput("held_done1", 64'(done_ticks[1]), 64'(2 * FRAME_A + 1));
        checkOutput("held_strobes", 64'(strobes), 64'd40);
        checkOutput("held_sum", 64'(sum), 64'(model_sum(er, 20)));
        start = 1'b0;
        repeat (100) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
